// File: rtl/game_pkg.sv
// Shared constants and types for the game's player/obstacle logic.
// Holds the colours, screen geometry and the collision FSM state encoding.
package game_pkg;

   localparam logic [11:0] OBSTACLE_RGB    = 12'hfff;
   localparam logic [11:0] BLINK_RGB       = 12'hf00;
   localparam logic [11:0] PLAYER_RGB      = 12'h0f0;
   localparam int          PLAYER_BOX      = 20;
   localparam int          SCREEN_H_ACTIVE = 1024;
   localparam int          SCREEN_V_ACTIVE = 768;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_INVULN = 2'd2,
      ST_DEAD   = 2'd3
   } coll_state_e;

endpackage

// File: rtl/box_hit_test.sv
// Combinational test: is the current pixel inside a square box anchored at (box_x, box_y)?
// Sums are 13 bits wide so a box near the right/bottom edge never wraps to zero.
module box_hit_test #(
   parameter int BOX_SIZE = 20
) (
   input  logic [11:0] hcount_i,
   input  logic [11:0] vcount_i,
   input  logic [11:0] box_x_i,
   input  logic [11:0] box_y_i,
   output logic        in_box_o
);

   logic [12:0] x_end;
   logic [12:0] y_end;
   logic        in_x;
   logic        in_y;

   assign x_end = {1'b0, box_x_i} + 13'(BOX_SIZE - 1);
   assign y_end = {1'b0, box_y_i} + 13'(BOX_SIZE - 1);

   assign in_x = (hcount_i >= box_x_i) && ({1'b0, hcount_i} <= x_end);
   assign in_y = (vcount_i >= box_y_i) && ({1'b0, vcount_i} <= y_end);

   assign in_box_o = in_x && in_y;

endmodule

// File: rtl/obstacle_collision_detector.sv
// Accumulates obstacle/player overlap over a frame, decides hits at frame end and
// manages lives, immunity and game over; also forwards the pixel stream with one cycle of delay.
module obstacle_collision_detector
   import game_pkg::*;
#(
   parameter logic [11:0] OBSTACLE_COLOR = OBSTACLE_RGB,
   parameter int          PLAYER_SIZE    = PLAYER_BOX,
   parameter int          LIVES_INIT     = 3,
   parameter int          INVULN_FRAMES  = 60,
   parameter int          V_ACTIVE       = SCREEN_V_ACTIVE,
   parameter logic [11:0] BLINK_COLOR    = BLINK_RGB
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic [11:0] vcount_in,
   input  logic [11:0] hcount_in,
   input  logic [11:0] rgb_in,
   input  logic [11:0] player_x,
   input  logic [11:0] player_y,
   input  logic        game_on,
   output logic [11:0] rgb_out,
   output logic        hit,
   output logic [1:0]  lives,
   output logic        invulnerable,
   output logic        game_over,
   output logic [1:0]  state_dbg
);

   localparam logic [1:0] LIVES_LOAD = 2'(LIVES_INIT);
   localparam logic [7:0] CNT_LAST   = 8'(INVULN_FRAMES - 1);

   coll_state_e state_q;
   logic [11:0] rgb_q;
   logic        hit_q;
   logic [1:0]  lives_q;
   logic        inv_q;
   logic        go_q;
   logic        flag_q;
   logic        flag_d;
   logic [7:0]  cnt_q;

   logic        in_box;
   logic        eval;
   logic        overlap;
   logic        frame_hit;
   logic        blink;

   box_hit_test #(
      .BOX_SIZE (PLAYER_SIZE)
   ) u_box (
      .hcount_i (hcount_in),
      .vcount_i (vcount_in),
      .box_x_i  (player_x),
      .box_y_i  (player_y),
      .in_box_o (in_box)
   );

   assign eval    = (hcount_in == 12'd0) && (vcount_in == 12'(V_ACTIVE));
   assign overlap = in_box && (rgb_in == OBSTACLE_COLOR) &&
                    ((state_q == ST_ARMED) || (state_q == ST_INVULN));
   // Overlap on the eval cycle itself still belongs to the frame being judged.
   assign frame_hit = eval && (flag_q || overlap);
   assign flag_d    = eval ? 1'b0 : (flag_q || overlap);
   assign blink     = in_box && inv_q && cnt_q[2];

   always_ff @(posedge pclk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         rgb_q   <= '0;
         hit_q   <= 1'b0;
         lives_q <= LIVES_LOAD;
         inv_q   <= 1'b0;
         go_q    <= 1'b0;
         flag_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         rgb_q  <= blink ? BLINK_COLOR : rgb_in;
         hit_q  <= 1'b0;
         flag_q <= flag_d;
         case (state_q)
            ST_IDLE: begin
               if (game_on) begin
                  state_q <= ST_ARMED;
                  lives_q <= LIVES_LOAD;
                  flag_q  <= 1'b0;
               end
            end
            ST_ARMED: begin
               if (!game_on) begin
                  state_q <= ST_IDLE;
                  inv_q   <= 1'b0;
               end else if (frame_hit && (lives_q != 2'd0)) begin
                  hit_q   <= 1'b1;
                  lives_q <= lives_q - 2'd1;
                  if (lives_q == 2'd1) begin
                     state_q <= ST_DEAD;
                     go_q    <= 1'b1;
                  end else begin
                     state_q <= ST_INVULN;
                     cnt_q   <= '0;
                     inv_q   <= 1'b1;
                  end
               end
            end
            ST_INVULN: begin
               if (!game_on) begin
                  state_q <= ST_IDLE;
                  inv_q   <= 1'b0;
               end else if (eval) begin
                  cnt_q <= cnt_q + 8'd1;
                  if (cnt_q == CNT_LAST) begin
                     state_q <= ST_ARMED;
                     inv_q   <= 1'b0;
                  end
               end
            end
            ST_DEAD: begin
               lives_q <= 2'd0;
               if (!game_on) begin
                  state_q <= ST_IDLE;
                  go_q    <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign rgb_out      = rgb_q;
   assign hit          = hit_q;
   assign lives        = lives_q;
   assign invulnerable = inv_q;
   assign game_over    = go_q;
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_obstacle_collision_detector.sv
// Bench for obstacle_collision_detector: directed frames drive the pixel stream,
// expected outputs go into a queue and a monitor compares them after every edge.
module tb_obstacle_collision_detector;
   import game_pkg::*;

   localparam int EXP_W = 19;

   logic        pclk = 1'b0;
   logic        rst;
   logic [11:0] vcount_in;
   logic [11:0] hcount_in;
   logic [11:0] rgb_in;
   logic [11:0] player_x;
   logic [11:0] player_y;
   logic        game_on;
   logic [11:0] rgb_out;
   logic        hit;
   logic [1:0]  lives;
   logic        invulnerable;
   logic        game_over;
   logic [1:0]  state_dbg;

   obstacle_collision_detector dut (
      .pclk         (pclk),
      .rst          (rst),
      .vcount_in    (vcount_in),
      .hcount_in    (hcount_in),
      .rgb_in       (rgb_in),
      .player_x     (player_x),
      .player_y     (player_y),
      .game_on      (game_on),
      .rgb_out      (rgb_out),
      .hit          (hit),
      .lives        (lives),
      .invulnerable (invulnerable),
      .game_over    (game_over),
      .state_dbg    (state_dbg)
   );

   // clock
   always #5 pclk = ~pclk;

   // scoreboard: {rgb, hit, lives, inv, game_over, state}
   logic [EXP_W-1:0] exp_q[$];
   string            tag_q[$];
   int               n_tests = 0;
   int               n_fail  = 0;

   logic             e_hit;
   logic [1:0]       e_lives;
   logic             e_inv;
   logic             e_go;
   logic [1:0]       e_st;
   logic [7:0]       inv_k;

   task automatic cyc(input logic [11:0] h, input logic [11:0] v, input logic [11:0] rgb,
                      input logic [11:0] exp_rgb, input string tag);
      hcount_in = h;
      vcount_in = v;
      rgb_in    = rgb;
      exp_q.push_back({exp_rgb, e_hit, e_lives, e_inv, e_go, e_st});
      tag_q.push_back(tag);
      @(posedge pclk);
      #1;
   endtask

   // One frame: background pixel, one chosen pixel, then the eval cycle.
   task automatic frame(input logic [11:0] h, input logic [11:0] v, input logic [11:0] rgb,
                        input logic inb, input logic f_hit, input logic [1:0] f_lives,
                        input logic f_inv, input logic f_go, input logic [1:0] f_st,
                        input string tag);
      logic pre_inv;
      pre_inv = e_inv;
      cyc(12'd5, 12'd5, 12'h123, 12'h123, {tag, "/bg"});
      cyc(h, v, rgb, (inb && e_inv && inv_k[2]) ? BLINK_RGB : rgb, {tag, "/px"});
      e_hit   = f_hit;
      e_lives = f_lives;
      e_inv   = f_inv;
      e_go    = f_go;
      e_st    = f_st;
      cyc(12'd0, 12'd768, 12'h000, 12'h000, {tag, "/eval"});
      e_hit = 1'b0;
      if (f_hit) inv_k = 8'd0;
      else if (pre_inv) inv_k = inv_k + 8'd1;
   endtask

   // monitor
   initial begin
      logic [EXP_W-1:0] e;
      logic [EXP_W-1:0] act;
      string            t;
      forever begin
         @(posedge pclk);
         #2;
         if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            t   = tag_q.pop_front();
            act = {rgb_out, hit, lives, invulnerable, game_over, state_dbg};
            n_tests++;
            if (act[18:7] !== e[18:7]) begin
               n_fail++;
               $display("FAIL %s rgb_out: got %h want %h", t, act[18:7], e[18:7]);
            end
            n_tests++;
            if (act[6:0] !== e[6:0]) begin
               n_fail++;
               $display("FAIL %s status{hit,lives,inv,go,st}: got %b_%0d_%b_%b_%0d want %b_%0d_%b_%b_%0d",
                        t, act[6], act[5:4], act[3], act[2], act[1:0],
                        e[6], e[5:4], e[3], e[2], e[1:0]);
            end
         end
      end
   end

   // watchdog
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst      = 1'b0;
      game_on  = 1'b0;
      player_x = 12'd400;
      player_y = 12'd400;
      inv_k    = 8'd0;
      e_hit    = 1'b0;
      e_lives  = 2'd3;
      e_inv    = 1'b0;
      e_go     = 1'b0;
      e_st     = ST_IDLE;

      // reset and idle
      cyc(12'd100, 12'd100, 12'hfff, 12'h000, "reset0");
      cyc(12'd405, 12'd405, 12'hfff, 12'h000, "reset1");
      rst = 1'b1;
      cyc(12'd10, 12'd10, 12'h0aa, 12'h0aa, "idle");
      game_on = 1'b1;
      e_st    = ST_ARMED;
      cyc(12'd11, 12'd10, 12'h0ab, 12'h0ab, "start");

      // obstacle-free frames, player at (400,400)
      frame(12'd405, 12'd405, 12'h0f0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, ST_ARMED, "clean0");
      frame(12'd419, 12'd419, 12'h777, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, ST_ARMED, "clean1");
      frame(12'd400, 12'd400, 12'hffe, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, ST_ARMED, "clean2");
      frame(12'd420, 12'd400, 12'hfff, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, ST_ARMED, "clean_out");

      // laser across x 341..371, player at (350,400)
      player_x = 12'd350;
      player_y = 12'd400;
      cyc(12'd341, 12'd317, 12'hfff, 12'hfff, "laser_out0");
      cyc(12'd371, 12'd399, 12'hfff, 12'hfff, "laser_out1");
      frame(12'd355, 12'd410, 12'hfff, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, ST_INVULN, "hit1");
      for (int k = 1; k < 60; k++)
         frame(12'd360, 12'd405, 12'hfff, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, ST_INVULN, "inv_a");
      frame(12'd360, 12'd405, 12'hfff, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, ST_ARMED, "inv_a_end");
      frame(12'd360, 12'd405, 12'hfff, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, ST_INVULN, "hit2");
      for (int k = 1; k < 60; k++)
         frame(12'd360, 12'd405, 12'hfff, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, ST_INVULN, "inv_b");
      frame(12'd360, 12'd405, 12'hfff, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, ST_ARMED, "inv_b_end");
      frame(12'd360, 12'd405, 12'hfff, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, ST_DEAD, "hit3");
      frame(12'd360, 12'd405, 12'hfff, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, ST_DEAD, "dead_nohit");

      // game over release and restart
      game_on = 1'b0;
      e_st    = ST_IDLE;
      e_go    = 1'b0;
      cyc(12'd20, 12'd20, 12'h321, 12'h321, "stop_dead");
      game_on = 1'b1;
      e_st    = ST_ARMED;
      e_lives = 2'd3;
      cyc(12'd21, 12'd20, 12'h322, 12'h322, "restart");

      // box edges: (x+20,y+19) and (x+19,y+20) miss, (x+19,y+19) hits
      frame(12'd370, 12'd419, 12'hfff, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, ST_ARMED, "edge_x20");
      frame(12'd369, 12'd420, 12'hfff, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, ST_ARMED, "edge_y20");
      frame(12'd369, 12'd419, 12'hfff, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, ST_INVULN, "corner");

      // reset in the middle of immunity, counter at 30
      for (int k = 0; k < 30; k++)
         frame(12'd360, 12'd405, 12'hfff, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, ST_INVULN, "inv_c");
      cyc(12'd5, 12'd5, 12'h123, 12'h123, "pre_rst_bg");
      cyc(12'd360, 12'd405, 12'hfff, inv_k[2] ? BLINK_RGB : 12'hfff, "pre_rst_px");
      rst     = 1'b0;
      e_lives = 2'd3;
      e_inv   = 1'b0;
      e_go    = 1'b0;
      e_st    = ST_IDLE;
      cyc(12'd361, 12'd405, 12'hfff, 12'h000, "rst_mid");
      rst   = 1'b1;
      e_st  = ST_ARMED;
      inv_k = 8'd0;
      cyc(12'd362, 12'd405, 12'hfff, 12'hfff, "rst_exit");
      frame(12'd5, 12'd6, 12'h456, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, ST_ARMED, "post_rst");

      // overlap on the eval cycle itself counts
      player_x = 12'd0;
      player_y = 12'd760;
      e_hit    = 1'b1;
      e_lives  = 2'd2;
      e_inv    = 1'b1;
      e_st     = ST_INVULN;
      cyc(12'd0, 12'd768, 12'hfff, 12'hfff, "eval_overlap");
      e_hit = 1'b0;
      cyc(12'd30, 12'd30, 12'h00f, 12'h00f, "after_eval");

      // game_on falls during immunity
      game_on = 1'b0;
      e_inv   = 1'b0;
      e_st    = ST_IDLE;
      cyc(12'd31, 12'd30, 12'h0f0, 12'h0f0, "stop_inv");
      cyc(12'd32, 12'd30, 12'h0f1, 12'h0f1, "idle_hold");

      // drain
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge pclk);
      #3;
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d entries left, want 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
